// File: rtl/uart_rx_os16_pkg.sv
// Shared types, constants and helpers for the SNN UART receive/transmit path.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state for 8E1 frames).
package snn_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] VOTE_S0     = 4'd7;
  localparam logic [3:0] VOTE_S1     = 4'd8;
  localparam logic [3:0] VOTE_S2     = 4'd9;
  localparam logic [3:0] STOP_DECIDE = 4'd9;
  localparam logic [3:0] LAST_TICK   = 4'd15;

  // Rounded clocks per 1/OVERSAMPLE bit period.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even-parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_os16_baud_tick_gen.sv
// Prescaler producing a registered one-clock tick every DIV enabled clocks.
// Synchronous clear restarts the count from zero; shared with the transmit side.
module baud_tick_gen #(
  parameter int DIV = 326
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;
  logic          tick_r;

  // Prescaler count and tick register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r  <= '0;
        tick_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + ONE;
        tick_r <= 1'b0;
      end
    end else begin
      tick_r <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver with 3-sample majority vote, false-start rejection
// and framing error detection. Define UART_RX_PARITY_EN for 8E1 frames with parity_err.
module uart_rx_os16
  import snn_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int TICK_DIV = baud_div(CLK_FREQ_HZ, BAUD);

  rx_state_t  state_r, state_nx;
  logic [3:0] tick_cnt_r, tick_cnt_nx;
  logic [2:0] bit_idx_r, bit_idx_nx;
  logic [7:0] shift_r, shift_nx;
  logic [1:0] samp_r, samp_nx;
  logic       bit_r, bit_nx;
  logic [7:0] data_r, data_nx;
  logic       rdy_r, rdy_nx;
  logic       ferr_r, ferr_nx;
`ifdef UART_RX_PARITY_EN
  logic       par_bad_r, par_bad_nx;
  logic       perr_r, perr_nx;
`endif
  logic       tick_s, clr_s, en_s, vote_s;

  // Prescaler stays cleared in IDLE and restarts on the same cycle the start edge is seen.
  assign clr_s = (state_nx == IDLE);
  assign en_s  = (state_r != IDLE) | ~rx;

  baud_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .en    (en_s),
    .tick  (tick_s)
  );

  // Next-state, sampling and strobe logic.
  always_comb begin
    state_nx    = state_r;
    tick_cnt_nx = tick_cnt_r;
    bit_idx_nx  = bit_idx_r;
    shift_nx    = shift_r;
    samp_nx     = samp_r;
    bit_nx      = bit_r;
    data_nx     = data_r;
    rdy_nx      = 1'b0;
    ferr_nx     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nx  = par_bad_r;
    perr_nx     = 1'b0;
`endif
    vote_s      = maj3(samp_r[0], samp_r[1], rx);

    if (tick_s) begin
      tick_cnt_nx = tick_cnt_r + 4'd1;
      if (tick_cnt_r == VOTE_S0) begin
        samp_nx[0] = rx;
      end else if (tick_cnt_r == VOTE_S1) begin
        samp_nx[1] = rx;
      end else if (tick_cnt_r == VOTE_S2) begin
        bit_nx = vote_s;
      end else begin
        bit_nx = bit_r;
      end
    end else begin
      tick_cnt_nx = tick_cnt_r;
    end

    case (state_r)
      IDLE: begin
`ifdef UART_RX_PARITY_EN
        par_bad_nx = 1'b0;
`endif
        if (!rx) begin
          state_nx = START;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        // A start bit that votes high was only a glitch.
        if (tick_s && tick_cnt_r == LAST_TICK) begin
          state_nx = bit_r ? IDLE : DATA;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (tick_s && tick_cnt_r == LAST_TICK) begin
          shift_nx   = {bit_r, shift_r[7:1]};
          bit_idx_nx = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            state_nx = DATA;
          end
        end else begin
          state_nx = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_s && tick_cnt_r == LAST_TICK) begin
          par_bad_nx = (bit_r != even_par(shift_r));
          state_nx   = STOP;
        end else begin
          state_nx = PARITY;
        end
      end
`endif
      STOP: begin
        // Decide mid-bit so a back-to-back start edge finds us already idle.
        if (tick_s && tick_cnt_r == STOP_DECIDE) begin
          if (!vote_s) begin
            ferr_nx     = 1'b1;
            state_nx    = WAIT_HIGH;
            tick_cnt_nx = 4'd0;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_r) begin
            perr_nx  = 1'b1;
            state_nx = IDLE;
`endif
          end else begin
            data_nx  = shift_r;
            rdy_nx   = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          state_nx = STOP;
        end
      end
      WAIT_HIGH: begin
        // Need 16 consecutive high ticks; any low sample restarts the count.
        if (!rx) begin
          tick_cnt_nx = 4'd0;
          state_nx    = WAIT_HIGH;
        end else if (tick_s && tick_cnt_r == LAST_TICK) begin
          state_nx = IDLE;
        end else begin
          state_nx = WAIT_HIGH;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    if (state_nx == IDLE) begin
      tick_cnt_nx = 4'd0;
      bit_idx_nx  = 3'd0;
    end else begin
      bit_idx_nx  = bit_idx_nx;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      tick_cnt_r <= 4'd0;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      samp_r     <= 2'b00;
      bit_r      <= 1'b0;
      data_r     <= 8'h00;
      rdy_r      <= 1'b0;
      ferr_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_r  <= 1'b0;
      perr_r     <= 1'b0;
`endif
    end else begin
      state_r    <= state_nx;
      tick_cnt_r <= tick_cnt_nx;
      bit_idx_r  <= bit_idx_nx;
      shift_r    <= shift_nx;
      samp_r     <= samp_nx;
      bit_r      <= bit_nx;
      data_r     <= data_nx;
      rdy_r      <= rdy_nx;
      ferr_r     <= ferr_nx;
`ifdef UART_RX_PARITY_EN
      par_bad_r  <= par_bad_nx;
      perr_r     <= perr_nx;
`endif
    end
  end

  assign rx_data   = data_r;
  assign rx_rdy    = rdy_r;
  assign frame_err = ferr_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: frame table, corner sequences and random
// frames scored against an expected-event queue built from the frame rules.
`timescale 1ns/1ps
module tb_uart_rx_os16;

  localparam int CLK_HZ = 307_200;
  localparam int BAUD_R = 9_600;
  localparam int TD     = (CLK_HZ + BAUD_R * 8) / (BAUD_R * 16);
  localparam int BITC   = 16 * TD;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Nominal strobe delay measured from the cycle the start bit is driven
  // (first low sample is one clock later); tolerance is +-1 clock.
  localparam int LAT_C = (9 * 16 + 10) * TD + 1 + 1 + PAR_BITS * 16 * TD;

  localparam int K_RDY  = 0;
  localparam int K_FERR = 1;
  localparam int K_PERR = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_rdy, frame_err, parity_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_count = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         start;
  } ev_t;
  ev_t exp_q[$];
  logic [7:0] last_good = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    logic       par_ok;
    int         low_after;
    int         gap;
    int         kind;
  } vec_t;
  vec_t tbl[7];

  uart_rx_os16 #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected event.
  int   m_n, m_kind, m_lat;
  ev_t  m_e;
  always @(negedge clk) begin
    if (rst_n) begin
      m_n = int'(rx_rdy) + int'(frame_err) + int'(parity_err);
      if (rx_rdy) rdy_count++;
      if (m_n > 1) begin
        checks++;
        errors++;
        $display("FAIL strobe_exclusive: got rdy=%0b ferr=%0b perr=%0b expected one at most",
                 rx_rdy, frame_err, parity_err);
      end else if (m_n == 1) begin
        m_kind = rx_rdy ? K_RDY : (frame_err ? K_FERR : K_PERR);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got kind %0d data %02h expected none (cycle %0d)",
                   m_kind, rx_data, cyc);
        end else begin
          m_e = exp_q.pop_front();
          chk("strobe_kind", m_kind, m_e.kind);
          chk("rx_data", {24'd0, rx_data}, {24'd0, m_e.data});
          m_lat = cyc - m_e.start;
          checks++;
          if (m_lat < LAT_C - 1 || m_lat > LAT_C + 1) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d +-1", m_lat, LAT_C);
          end
        end
      end
    end
  end

  function automatic int outcome(input logic stop_v, input logic par_ok);
    if (!stop_v) return K_FERR;
    if (!par_ok) return K_PERR;
    return K_RDY;
  endfunction

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BITC) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_ok,
                            input int low_after, input int gap, input int kind);
    ev_t  e;
    logic p;
    e.kind  = kind;
    e.start = cyc;
    if (kind == K_RDY) begin
      last_good = d;
    end
    e.data = last_good;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    p = ^d;
    drive_bit(par_ok ? p : ~p);
`else
    p = par_ok;
`endif
    drive_bit(stop_v);
    repeat (low_after) drive_bit(1'b0);
    repeat (gap) drive_bit(1'b1);
  endtask

  int rdy_before;
  logic [7:0] rd;
  logic       rs, rp;
  int         rl, rg;

  initial begin
    tbl[0] = '{8'h55, 1'b1, 1'b1, 0, 2, K_RDY};
    tbl[1] = '{8'h3C, 1'b0, 1'b1, 3, 2, K_FERR};
    tbl[2] = '{8'h0F, 1'b1, 1'b1, 0, 2, K_RDY};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 0, 1, K_RDY};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 0, 1, K_RDY};
    tbl[5] = '{8'h80, 1'b0, 1'b1, 0, 2, K_FERR};
    tbl[6] = '{8'h01, 1'b1, 1'b1, 0, 1, K_RDY};

    repeat (5) @(posedge clk);
    #1;
    chk("reset_rx_data", {24'd0, rx_data}, 32'h0);
    chk("reset_rx_rdy", {31'd0, rx_rdy}, 32'h0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'h0);
    chk("reset_parity_err", {31'd0, parity_err}, 32'h0);
    rst_n = 1'b1;
    repeat (BITC) @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].data, tbl[i].stop_v, tbl[i].par_ok, tbl[i].low_after, tbl[i].gap,
                 tbl[i].kind);
    end

    // Short low glitch must be rejected; the next frame still lands.
    rx = 1'b0;
    repeat (4 * TD) @(posedge clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'hA3, 1'b1, 1'b1, 0, 2, K_RDY);

    // Reset in the middle of bit 4 of 0xFF; the aborted frame must vanish.
    drive_bit(1'b0);
    repeat (4) drive_bit(1'b1);
    rx = 1'b1;
    repeat (BITC / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_good = 8'h00;
    chk("post_reset_rx_data", {24'd0, rx_data}, 32'h0);
    repeat (BITC / 2 - 3) @(posedge clk);
    #1;
    repeat (5) drive_bit(1'b1);
    send_frame(8'h81, 1'b1, 1'b1, 0, 2, K_RDY);
    chk("after_abort_rx_data", {24'd0, rx_data}, 32'h81);

    // Back-to-back frames with no idle gap.
    rdy_before = rdy_count;
    for (int i = 0; i < 96; i++) begin
      send_frame(8'(i * 11), 1'b1, 1'b1, 0, 0, K_RDY);
    end
    drive_bit(1'b1);
    chk("b2b_rdy_count", rdy_count - rdy_before, 96);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 0, 1, K_RDY);
    send_frame(8'h07, 1'b1, 1'b0, 0, 1, K_PERR);
    chk("parity_keep_rx_data", {24'd0, rx_data}, 32'h07);
`endif

    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      rp = ($urandom_range(0, 7) != 0);
`else
      rp = 1'b1;
`endif
      rl = rs ? 0 : $urandom_range(0, 2);
      rg = rs ? $urandom_range(0, 2) : 2;
      send_frame(rd, rs, rp, rl, rg, outcome(rs, rp));
    end

    repeat (4 * BITC) @(posedge clk);
    #1;
    chk("pending_events", exp_q.size(), 0);
    chk("final_rx_data", {24'd0, rx_data}, {24'd0, last_good});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

Oversampling UART receiver for the SNN image-load path. It deserialises 8N1 frames (optionally 8E1) from the already double-flopped `uart_rx_synch` line and presents each good byte on `rx_data` with a one-cycle `rx_rdy` strobe. The strobe feeds the top-level load FSM, which latches the byte and unpacks it into the 1-bit input RAM. It adds 16x oversampling, 3-sample majority voting, false-start rejection and framing/parity error flags.

## Interface
Parameters:
- `CLK_FREQ_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 9600: line rate.
- `TICK_DIV`, (CLK_FREQ_HZ + BAUD*8)/(BAUD*16): clocks per 1/16-bit tick. Derived localparam; equals 326 at the defaults.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `rx`, input, 1: serial line, already synchronised; idles high.
- `rx_data`, output, 8: last good byte. Holds until the next good byte.
- `rx_rdy`, output, 1: one-cycle strobe; `rx_data` is valid in the same cycle.
- `frame_err`, output, 1: one-cycle strobe; stop bit sampled low.
- `parity_err`, output, 1: one-cycle strobe; driven only with the parity macro, tied 0 otherwise.

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: prescaler and tick counter are held at 0. `rx`==0 moves the FSM to START and starts the prescaler in the same cycle.
- Prescaler counts 0..TICK_DIV-1 and emits `tick` at wrap. `tick_cnt[3:0]` increments on each `tick`.
- Vote: samples are taken at tick_cnt 7, 8, 9 of each bit; bit value = majority of the 3.
- START: at tick_cnt 15 with a majority-1 vote (glitch), go to IDLE with no strobe; majority 0, go to DATA.
- DATA: 8 bits, LSB first, shifted into `shift[7:0]`. `bit_idx[2:0]` wraps 7→0 on the transition to PARITY/STOP.
- PARITY: voted bit is compared with even parity of `shift`. A mismatch sets an internal `par_bad` flag.
- STOP: the decision is made at tick_cnt 9, not 15, to gain half a bit of margin for back-to-back frames.
  - Vote 1 and !par_bad: `rx_data`←`shift`, `rx_rdy` pulses, go to IDLE.
  - Vote 1 and par_bad: `parity_err` pulses, `rx_data` unchanged, go to IDLE.
  - Vote 0: `frame_err` pulses, `rx_data` unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stays until `rx`==1 for one full bit time (16 ticks), then goes to IDLE. This rejects breaks and no bytes are produced.
- Only one strobe fires per frame. `rx_rdy`, `frame_err` and `parity_err` are mutually exclusive.

## Timing
- Reset values: `rx_data`=8'h00, `rx_rdy`=0, `frame_err`=0, `parity_err`=0, state IDLE, all counters 0.
- Reset asserted mid-frame aborts immediately. After release the FSM waits in IDLE for the next falling edge. A frame whose start edge was missed is lost; no partial byte is ever emitted.
- Latency: strobe is registered in the cycle after the stop-bit tick_cnt 9 tick.
  - 8N1: (9*16+10)*TICK_DIV + 1 clocks after the first low sample, ±1.
  - 8E1: add 16*TICK_DIV clocks.
- Strobe width is exactly 1 clk. There is no backpressure: a consumer that misses it loses the byte.
- Back-to-back frames (start bit immediately after the stop bit) must be received without loss. IDLE is re-entered at least 6 ticks before the next start edge.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state is present; 11-bit 8E1 frame; `parity_err` is live.
- Undefined: 10-bit 8N1; PARITY state and `par_bad` are absent; `parity_err` is tied 1'b0.

## Structure
- Package `snn_uart_pkg`:
  - `rx_state_t` enum.
  - Constants: `OVERSAMPLE`=16, `VOTE_S0`/`VOTE_S1`/`VOTE_S2`=7/8/9, `STOP_DECIDE`=9.
  - Function `baud_div(clk_hz, baud)`.
- Sub-module `baud_tick_gen`: prescaler with sync clear/enable, one-cycle `tick` output. Reused later by the transmit side.

## Test plan
- 8N1 byte 0x55 at 9600 baud: exactly one `rx_rdy` pulse, `rx_data`=0x55, `frame_err`=0, latency within ±1 clk of the Timing formula.
- 784 back-to-back frames 0x00..0xFF repeating, no idle gap: 784 `rx_rdy` pulses with matching data in order, zero errors.
- 4-tick low glitch on an idle line: no strobe, FSM back in IDLE by tick 16. A following 0xA3 frame is received correctly.
- Frame 0x3C with stop bit forced low, then 3 bit-times low: one `frame_err`, `rx_data` keeps the prior value, no strobe until the line has been high for 16 ticks. A following 0x0F is received.
- `rst_n` pulsed low during bit 4 of 0xFF, then a clean 0x81: no output from the aborted frame, `rx_data`=0x81.
- With `UART_RX_PARITY_EN`: 0x07 sent with parity 1 gives `rx_rdy`; sent with parity 0 gives one `parity_err` and `rx_data` unchanged.
